// File: rtl/fwd_pkg.sv
// Shared types for the ALU operand forwarding block: FSM states, operand
// select codes and the zero-register index.
package fwd_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } fwd_state_t;

    typedef enum logic [1:0] {
        SEL_REG    = 2'd0,
        SEL_MEM    = 2'd1,
        SEL_WB     = 2'd2,
        SEL_SHADOW = 2'd3
    } op_sel_t;

    localparam int REG_ZERO = 0;
    localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/operand_select_mux.sv
// Per-operand source select: picks register-file, MEM, WB or shadow data from
// already-qualified hit flags and the replay request left by a load-use stall.
module operand_select_mux
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  force_reg,
    input  logic                  need,
    input  logic                  mem_fwd,
    input  logic                  wb_hit,
    input  logic                  sh_hit,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [DATA_WIDTH-1:0] shadow_data,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] operand
);

    op_sel_t sel_code;

    // The replay request outranks everything: the hazard-unit selects are
    // stale by the time the load reaches WB.
    always_comb begin
        sel_code = SEL_REG;
        if (force_reg)
            sel_code = SEL_REG;
        else if (need)
            sel_code = SEL_WB;
        else if (mem_fwd)
            sel_code = SEL_MEM;
        else if (wb_hit)
            sel_code = SEL_WB;
        else if (sh_hit)
            sel_code = SEL_SHADOW;
    end

    always_comb begin
        operand = reg_data;
        case (sel_code)
            SEL_MEM:    operand = mem_result;
            SEL_WB:     operand = wb_data;
            SEL_SHADOW: operand = shadow_data;
            default:    operand = reg_data;
        endcase
    end

    assign sel = sel_code;

endmodule

// File: rtl/alu_operand_forward.sv
// ALU-stage operand forwarding with load-use stall/replay and a one-entry
// writeback shadow. Define FWD_PERF_CNT_EN to add saturating event counters.
module alu_operand_forward
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MEM_TO_SREG1,
    input  logic                  MEM_TO_SREG2,
    input  logic                  WB_TO_SREG1,
    input  logic                  WB_TO_SREG2,
    input  logic [ADDR_WIDTH-1:0] SREG1_ADDR,
    input  logic [ADDR_WIDTH-1:0] SREG2_ADDR,
    input  logic [DATA_WIDTH-1:0] REG_DATA1,
    input  logic [DATA_WIDTH-1:0] REG_DATA2,
    input  logic [DATA_WIDTH-1:0] MEM_RESULT,
    input  logic                  MEM_WRITE_EN,
    input  logic                  MEM_IS_LOAD,
    input  logic [DATA_WIDTH-1:0] WB_DATA,
    input  logic [ADDR_WIDTH-1:0] WB_ADDR,
    input  logic                  WB_WRITE_EN,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]           FWD_MEM_COUNT,
    output logic [31:0]           FWD_WB_COUNT,
    output logic [31:0]           LOAD_STALL_COUNT,
`endif
    output logic [DATA_WIDTH-1:0] OPERAND1,
    output logic [DATA_WIDTH-1:0] OPERAND2,
    output logic                  STALL
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(REG_ZERO);

    fwd_state_t            state, next_state;
    logic                  need1, need2;
    logic                  shadow_valid;
    logic [ADDR_WIDTH-1:0] shadow_addr;
    logic [DATA_WIDTH-1:0] shadow_data;

    logic memhit1, memhit2, wbhit1, wbhit2, shhit1, shhit2;
    logic load_use;
    logic in_run, in_wait;
    logic [1:0] sel1, sel2;

    assign memhit1 = MEM_TO_SREG1 & MEM_WRITE_EN & (SREG1_ADDR != ADDR_ZERO);
    assign memhit2 = MEM_TO_SREG2 & MEM_WRITE_EN & (SREG2_ADDR != ADDR_ZERO);
    assign wbhit1  = WB_TO_SREG1 & WB_WRITE_EN & (SREG1_ADDR != ADDR_ZERO);
    assign wbhit2  = WB_TO_SREG2 & WB_WRITE_EN & (SREG2_ADDR != ADDR_ZERO);
    assign shhit1  = shadow_valid & (shadow_addr == SREG1_ADDR) & (SREG1_ADDR != ADDR_ZERO);
    assign shhit2  = shadow_valid & (shadow_addr == SREG2_ADDR) & (SREG2_ADDR != ADDR_ZERO);

    assign in_run   = (state == RUN);
    assign in_wait  = (state == LOAD_WAIT);
    assign load_use = MEM_IS_LOAD & (memhit1 | memhit2);

    // State register; needs record which operands the stalled load feeds.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RUN;
            need1 <= 1'b0;
            need2 <= 1'b0;
        end else begin
            state <= next_state;
            if (in_run && load_use) begin
                need1 <= memhit1;
                need2 <= memhit2;
            end else begin
                need1 <= 1'b0;
                need2 <= 1'b0;
            end
        end
    end

    // LOAD_WAIT always returns to RUN; MEM holds a bubble there, so no new
    // hazard can be declared back-to-back.
    always_comb begin
        next_state = state;
        case (state)
            RUN:       next_state = load_use ? LOAD_WAIT : RUN;
            LOAD_WAIT: next_state = RUN;
            default:   next_state = RUN;
        endcase
    end

    always_comb begin
        STALL = 1'b0;
        if (!RESET && in_run && load_use)
            STALL = 1'b1;
    end

    // Shadow covers the register file's read-before-write for a producer
    // that has already left WB.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow_valid <= 1'b0;
            shadow_addr  <= '0;
            shadow_data  <= '0;
        end else if (WB_WRITE_EN && (WB_ADDR != ADDR_ZERO)) begin
            shadow_valid <= 1'b1;
            shadow_addr  <= WB_ADDR;
            shadow_data  <= WB_DATA;
        end
    end

    operand_select_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux1 (
        .force_reg   (RESET),
        .need        (in_wait & need1),
        .mem_fwd     (in_run & memhit1 & ~MEM_IS_LOAD),
        .wb_hit      (wbhit1),
        .sh_hit      (shhit1),
        .reg_data    (REG_DATA1),
        .mem_result  (MEM_RESULT),
        .wb_data     (WB_DATA),
        .shadow_data (shadow_data),
        .sel         (sel1),
        .operand     (OPERAND1)
    );

    operand_select_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux2 (
        .force_reg   (RESET),
        .need        (in_wait & need2),
        .mem_fwd     (in_run & memhit2 & ~MEM_IS_LOAD),
        .wb_hit      (wbhit2),
        .sh_hit      (shhit2),
        .reg_data    (REG_DATA2),
        .mem_result  (MEM_RESULT),
        .wb_data     (WB_DATA),
        .shadow_data (shadow_data),
        .sel         (sel2),
        .operand     (OPERAND2)
    );

`ifdef FWD_PERF_CNT_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic mem_evt, wb_evt;

    // A load-use detect cycle counts as a MEM forward even though it stalls.
    assign mem_evt = ~RESET & in_run & (memhit1 | memhit2);
    assign wb_evt  = (op_sel_t'(sel1) inside {SEL_WB, SEL_SHADOW}) |
                     (op_sel_t'(sel2) inside {SEL_WB, SEL_SHADOW});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            FWD_MEM_COUNT    <= '0;
            FWD_WB_COUNT     <= '0;
            LOAD_STALL_COUNT <= '0;
        end else begin
            if (mem_evt) FWD_MEM_COUNT    <= sat_inc(FWD_MEM_COUNT);
            if (wb_evt)  FWD_WB_COUNT     <= sat_inc(FWD_WB_COUNT);
            if (STALL)   LOAD_STALL_COUNT <= sat_inc(LOAD_STALL_COUNT);
        end
    end
`else
    logic sel_unused;
    assign sel_unused = ^{sel1, sel2};
`endif

endmodule

// File: tb/tb_alu_operand_forward.sv
// Directed self-checking bench for alu_operand_forward (counter checks are
// compiled in when FWD_PERF_CNT_EN is defined).
module tb_alu_operand_forward;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          MEM_TO_SREG1, MEM_TO_SREG2, WB_TO_SREG1, WB_TO_SREG2;
    logic [AW-1:0] SREG1_ADDR, SREG2_ADDR, WB_ADDR;
    logic [DW-1:0] REG_DATA1, REG_DATA2, MEM_RESULT, WB_DATA;
    logic          MEM_WRITE_EN, MEM_IS_LOAD, WB_WRITE_EN;
    logic [DW-1:0] OPERAND1, OPERAND2;
    logic          STALL;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]   FWD_MEM_COUNT, FWD_WB_COUNT, LOAD_STALL_COUNT;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    alu_operand_forward #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .MEM_TO_SREG1     (MEM_TO_SREG1),
        .MEM_TO_SREG2     (MEM_TO_SREG2),
        .WB_TO_SREG1      (WB_TO_SREG1),
        .WB_TO_SREG2      (WB_TO_SREG2),
        .SREG1_ADDR       (SREG1_ADDR),
        .SREG2_ADDR       (SREG2_ADDR),
        .REG_DATA1        (REG_DATA1),
        .REG_DATA2        (REG_DATA2),
        .MEM_RESULT       (MEM_RESULT),
        .MEM_WRITE_EN     (MEM_WRITE_EN),
        .MEM_IS_LOAD      (MEM_IS_LOAD),
        .WB_DATA          (WB_DATA),
        .WB_ADDR          (WB_ADDR),
        .WB_WRITE_EN      (WB_WRITE_EN),
`ifdef FWD_PERF_CNT_EN
        .FWD_MEM_COUNT    (FWD_MEM_COUNT),
        .FWD_WB_COUNT     (FWD_WB_COUNT),
        .LOAD_STALL_COUNT (LOAD_STALL_COUNT),
`endif
        .OPERAND1         (OPERAND1),
        .OPERAND2         (OPERAND2),
        .STALL            (STALL)
    );

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // another time unit later, well clear of either edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        MEM_TO_SREG1 = 0; MEM_TO_SREG2 = 0; WB_TO_SREG1 = 0; WB_TO_SREG2 = 0;
        SREG1_ADDR = 0; SREG2_ADDR = 0; WB_ADDR = 0;
        REG_DATA1 = 0; REG_DATA2 = 0; MEM_RESULT = 0; WB_DATA = 0;
        MEM_WRITE_EN = 0; MEM_IS_LOAD = 0; WB_WRITE_EN = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        RESET = 1;
        tick();
        RESET = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 1;
        MEM_TO_SREG1 = 1; MEM_WRITE_EN = 1; MEM_IS_LOAD = 1; SREG1_ADDR = 3;
        REG_DATA1 = 32'h77; REG_DATA2 = 32'h88;
        WB_WRITE_EN = 1; WB_ADDR = 9; WB_DATA = 32'h99; WB_TO_SREG2 = 1; SREG2_ADDR = 9;
        settle();
        tests_run++;
        if (STALL !== 1'b0) begin
            tests_failed++; $display("FAIL reset_stall: got %b want 0", STALL);
        end
        tests_run++;
        if (OPERAND1 !== 32'h77) begin
            tests_failed++; $display("FAIL reset_op1: got %h want 00000077", OPERAND1);
        end
        tests_run++;
        if (OPERAND2 !== 32'h88) begin
            tests_failed++; $display("FAIL reset_op2: got %h want 00000088", OPERAND2);
        end
        tick();
        RESET = 0;
        clear_inputs();
        SREG1_ADDR = 9; REG_DATA1 = 32'h12;
        settle();
        tests_run++;
        if (OPERAND1 !== 32'h12) begin
            tests_failed++; $display("FAIL reset_no_shadow: got %h want 00000012", OPERAND1);
        end
    endtask

    task automatic test_mem_forward();
        apply_reset();
        MEM_TO_SREG1 = 1; MEM_WRITE_EN = 1; SREG1_ADDR = 5;
        MEM_RESULT = 32'h1234; REG_DATA1 = 0;
        settle();
        tests_run++;
        if (OPERAND1 !== 32'h1234) begin
            tests_failed++; $display("FAIL mem_fwd_op1: got %h want 00001234", OPERAND1);
        end
        tests_run++;
        if (STALL !== 1'b0) begin
            tests_failed++; $display("FAIL mem_fwd_stall: got %b want 0", STALL);
        end
        tick();
        clear_inputs();
        MEM_TO_SREG2 = 1; MEM_WRITE_EN = 0; SREG2_ADDR = 6;
        MEM_RESULT = 32'h4321; REG_DATA2 = 32'h5;
        settle();
        tests_run++;
        if (OPERAND2 !== 32'h5) begin
            tests_failed++; $display("FAIL mem_fwd_no_wen: got %h want 00000005", OPERAND2);
        end
    endtask

    task automatic test_priority_x0();
        apply_reset();
        MEM_TO_SREG2 = 1; WB_TO_SREG2 = 1; MEM_WRITE_EN = 1; WB_WRITE_EN = 1;
        MEM_RESULT = 32'hAA; WB_DATA = 32'hBB; SREG2_ADDR = 7; WB_ADDR = 7;
        settle();
        tests_run++;
        if (OPERAND2 !== 32'hAA) begin
            tests_failed++; $display("FAIL prio_mem_over_wb: got %h want 000000aa", OPERAND2);
        end
        SREG2_ADDR = 0; REG_DATA2 = 0;
        settle();
        tests_run++;
        if (OPERAND2 !== 32'h0) begin
            tests_failed++; $display("FAIL x0_no_fwd: got %h want 00000000", OPERAND2);
        end
        SREG2_ADDR = 7; MEM_TO_SREG2 = 0;
        settle();
        tests_run++;
        if (OPERAND2 !== 32'hBB) begin
            tests_failed++; $display("FAIL wb_fwd: got %h want 000000bb", OPERAND2);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        MEM_IS_LOAD = 1; MEM_TO_SREG1 = 1; MEM_WRITE_EN = 1; SREG1_ADDR = 3;
        REG_DATA1 = 32'h0;
        settle();
        tests_run++;
        if (STALL !== 1'b1) begin
            tests_failed++; $display("FAIL load_use_stall: got %b want 1", STALL);
        end
        tick();
        MEM_IS_LOAD = 0; MEM_TO_SREG1 = 0; MEM_WRITE_EN = 0;
        WB_DATA = 32'hDEAD; WB_ADDR = 3; WB_WRITE_EN = 1;
        settle();
        tests_run++;
        if (OPERAND1 !== 32'hDEAD) begin
            tests_failed++; $display("FAIL load_replay_op1: got %h want 0000dead", OPERAND1);
        end
        tests_run++;
        if (STALL !== 1'b0) begin
            tests_failed++; $display("FAIL load_replay_stall: got %b want 0", STALL);
        end
        tick();
        WB_WRITE_EN = 0; WB_DATA = 32'h1; SREG1_ADDR = 4; REG_DATA1 = 32'h44;
        settle();
        tests_run++;
        if (OPERAND1 !== 32'h44) begin
            tests_failed++; $display("FAIL load_need_cleared: got %h want 00000044", OPERAND1);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        MEM_IS_LOAD = 1; MEM_TO_SREG2 = 1; MEM_WRITE_EN = 1; SREG2_ADDR = 4;
        settle();
        tests_run++;
        if (STALL !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_first_stall: got %b want 1", STALL);
        end
        tick();
        WB_DATA = 32'hCAFE; WB_WRITE_EN = 1; WB_ADDR = 4; REG_DATA2 = 32'h1;
        SREG1_ADDR = 6; REG_DATA1 = 32'h66;
        settle();
        tests_run++;
        if (STALL !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_no_second_stall: got %b want 0", STALL);
        end
        tests_run++;
        if (OPERAND2 !== 32'hCAFE) begin
            tests_failed++; $display("FAIL b2b_replay_op2: got %h want 0000cafe", OPERAND2);
        end
        tests_run++;
        if (OPERAND1 !== 32'h66) begin
            tests_failed++; $display("FAIL b2b_other_op: got %h want 00000066", OPERAND1);
        end
        tick();
        clear_inputs();
        SREG2_ADDR = 4; REG_DATA2 = 32'h2;
        settle();
        tests_run++;
        if (OPERAND2 !== 32'hCAFE) begin
            tests_failed++; $display("FAIL b2b_shadow_after: got %h want 0000cafe", OPERAND2);
        end
    endtask

    task automatic test_shadow();
        apply_reset();
        WB_WRITE_EN = 1; WB_ADDR = 9; WB_DATA = 32'h55;
        tick();
        WB_WRITE_EN = 0; WB_ADDR = 0; WB_DATA = 0;
        SREG1_ADDR = 9; REG_DATA1 = 32'h11; SREG2_ADDR = 9; REG_DATA2 = 32'h22;
        settle();
        tests_run++;
        if (OPERAND1 !== 32'h55) begin
            tests_failed++; $display("FAIL shadow_op1: got %h want 00000055", OPERAND1);
        end
        tests_run++;
        if (OPERAND2 !== 32'h55) begin
            tests_failed++; $display("FAIL shadow_op2: got %h want 00000055", OPERAND2);
        end
        WB_WRITE_EN = 1; WB_ADDR = 0; WB_DATA = 32'h77;
        tick();
        WB_WRITE_EN = 0;
        settle();
        tests_run++;
        if (OPERAND1 !== 32'h55) begin
            tests_failed++; $display("FAIL shadow_x0_write: got %h want 00000055", OPERAND1);
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        MEM_IS_LOAD = 1; MEM_TO_SREG1 = 1; MEM_WRITE_EN = 1; SREG1_ADDR = 3;
        tick();
        RESET = 1;
        MEM_IS_LOAD = 0; MEM_TO_SREG1 = 0; MEM_WRITE_EN = 0;
        WB_DATA = 32'hBEEF; REG_DATA1 = 32'h33;
        settle();
        tests_run++;
        if (STALL !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_stall: got %b want 0", STALL);
        end
        tests_run++;
        if (OPERAND1 !== 32'h33) begin
            tests_failed++; $display("FAIL rst_mid_op1: got %h want 00000033", OPERAND1);
        end
        tick();
        RESET = 0;
        SREG1_ADDR = 9; REG_DATA1 = 32'h21;
        settle();
        tests_run++;
        if (OPERAND1 !== 32'h21) begin
            tests_failed++; $display("FAIL rst_mid_after: got %h want 00000021", OPERAND1);
        end
    endtask

`ifdef FWD_PERF_CNT_EN
    task automatic test_counters();
        apply_reset();
        settle();
        tests_run++;
        if ({FWD_MEM_COUNT, FWD_WB_COUNT, LOAD_STALL_COUNT} !== 96'h0) begin
            tests_failed++;
            $display("FAIL cnt_reset: got %h %h %h want 0 0 0",
                     FWD_MEM_COUNT, FWD_WB_COUNT, LOAD_STALL_COUNT);
        end
        MEM_TO_SREG1 = 1; MEM_WRITE_EN = 1; SREG1_ADDR = 5; MEM_RESULT = 32'h10;
        tick();
        MEM_TO_SREG1 = 0; MEM_TO_SREG2 = 1; SREG2_ADDR = 6;
        tick();
        MEM_TO_SREG2 = 0; MEM_TO_SREG1 = 1; SREG1_ADDR = 3; MEM_IS_LOAD = 1;
        tick();
        clear_inputs();
        SREG1_ADDR = 3; WB_DATA = 32'h3;
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (FWD_MEM_COUNT !== 32'd3) begin
            tests_failed++; $display("FAIL cnt_mem: got %0d want 3", FWD_MEM_COUNT);
        end
        tests_run++;
        if (LOAD_STALL_COUNT !== 32'd1) begin
            tests_failed++; $display("FAIL cnt_stall: got %0d want 1", LOAD_STALL_COUNT);
        end
        tests_run++;
        if (FWD_WB_COUNT !== 32'd1) begin
            tests_failed++; $display("FAIL cnt_wb: got %0d want 1", FWD_WB_COUNT);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1;
        clear_inputs();
        tick();
        test_reset();
        test_mem_forward();
        test_priority_x0();
        test_load_use();
        test_back_to_back();
        test_shadow();
        test_reset_mid_stall();
`ifdef FWD_PERF_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_operand_forward.md
Name: alu_operand_forward

Overview:
- ALU-stage consumer of the forwarding selects from the hazard-detection unit (MEM_TO_SREGx / WB_TO_SREGx).
- Builds the two ALU operands from register-file data, the MEM-stage result, the WB data, or a one-entry writeback shadow register.
- Detects load-use hazards, where the MEM-stage producer is a load. It raises a one-cycle STALL and replays the forward from WB on the next cycle.

Parameters:
- DATA_WIDTH, 32, operand/data width
- ADDR_WIDTH, 5, register address width

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- MEM_TO_SREG1  in  1  hazard-unit select: forward MEM result to operand 1
- MEM_TO_SREG2  in  1  hazard-unit select: forward MEM result to operand 2
- WB_TO_SREG1  in  1  hazard-unit select: forward WB data to operand 1
- WB_TO_SREG2  in  1  hazard-unit select: forward WB data to operand 2
- SREG1_ADDR  in  ADDR_WIDTH  ALU-stage rs1 address
- SREG2_ADDR  in  ADDR_WIDTH  ALU-stage rs2 address
- REG_DATA1  in  DATA_WIDTH  ID/EX-latched rs1 value
- REG_DATA2  in  DATA_WIDTH  ID/EX-latched rs2 value
- MEM_RESULT  in  DATA_WIDTH  MEM-stage ALU result
- MEM_WRITE_EN  in  1  MEM-stage instruction writes rd
- MEM_IS_LOAD  in  1  MEM-stage instruction is a load
- WB_DATA  in  DATA_WIDTH  writeback data
- WB_ADDR  in  ADDR_WIDTH  writeback rd
- WB_WRITE_EN  in  1  writeback enable
- OPERAND1  out  DATA_WIDTH  ALU operand 1
- OPERAND2  out  DATA_WIDTH  ALU operand 2
- STALL  out  1  freeze PC/IF/ID/EX, bubble into MEM

Behaviour:
- **Clocking and reset:** clock is CLK; RESET is synchronous, active-high, and sampled on the CLK rising edge.
- **Latency:** operand path and STALL are combinational from the current inputs and state (0-cycle latency). State, shadow and latched needs update on the CLK rising edge.
- **Reset:** state=RUN, need1=need2=0, shadow_valid=0, shadow_addr=0, shadow_data=0, counters=0.
- **Outputs during and after reset:** STALL=0 and OPERANDx=REG_DATAx while RESET=1 and until the next forwarding event.
- **Per-operand qualified hits** (x = 1, 2):
  - memhit = MEM_TO_SREGx & MEM_WRITE_EN & (SREGx_ADDR!=0)
  - wbhit = WB_TO_SREGx & WB_WRITE_EN & (SREGx_ADDR!=0)
  - shhit = shadow_valid & (shadow_addr==SREGx_ADDR) & (SREGx_ADDR!=0)
- **Operand priority in RUN (highest first):**
  - memhit & !MEM_IS_LOAD -> MEM_RESULT
  - wbhit -> WB_DATA
  - shhit -> shadow_data
  - otherwise REG_DATAx
- **Register x0:** never forwarded; OPERANDx=REG_DATAx regardless of selects.
- **FSM state RUN:**
  - Load-use condition: MEM_IS_LOAD & (memhit1 | memhit2).
  - If the condition holds: STALL=1; OPERANDs are don't-care (the downstream bubble discards them); latch need1=memhit1, need2=memhit2; next state LOAD_WAIT.
  - Otherwise: STALL=0; stay in RUN.
- **FSM state LOAD_WAIT:**
  - The load has advanced to WB.
  - needx=1 -> OPERANDx=WB_DATA, overriding the (now stale) hazard-unit selects.
  - needx=0 -> normal RUN priority, excluding the MEM path.
  - STALL=0; next state RUN; needs cleared.
- **Back-to-back loads:** a new load-use hazard is never declared in LOAD_WAIT. The MEM stage holds a bubble in that cycle.
- **Writeback shadow:**
  - Every cycle (all states), if WB_WRITE_EN & WB_ADDR!=0: shadow_addr<=WB_ADDR, shadow_data<=WB_DATA, shadow_valid<=1.
  - Otherwise the shadow holds its contents.
  - Purpose: covers the register file's read-before-write for producers three instructions back.
- **Reset mid-stall:** RESET in LOAD_WAIT forces RUN, clears the needs, and deasserts STALL in the same cycle.
- **Simultaneous MEM and WB select on the same operand:** MEM wins (youngest producer). For a load it stalls; WB is not used.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- When defined, adds three 32-bit saturating counters (reset 0, hold at 0xFFFFFFFF):
  - FWD_MEM_COUNT: cycles with any MEM forward.
  - FWD_WB_COUNT: cycles with any WB or shadow forward, including LOAD_WAIT.
  - LOAD_STALL_COUNT: STALL cycles.
- Each counter is exposed as a 32-bit output port.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- **Shared package fwd_pkg:**
  - FSM state enum: RUN, LOAD_WAIT.
  - 2-bit operand-select encoding: SEL_REG=0, SEL_MEM=1, SEL_WB=2, SEL_SHADOW=3.
  - Constant REG_ZERO=0.
- **Sub-module operand_select_mux:** instantiated twice. Each instance takes the qualified hits and needx and returns the select code plus the operand.
- The FSM and the shadow register live in the top level.

Test Plan:
- **MEM forward:** MEM_TO_SREG1=1, MEM_WRITE_EN=1, SREG1_ADDR=5, MEM_RESULT=0x1234, REG_DATA1=0 -> OPERAND1=0x1234, STALL=0.
- **Priority and x0:**
  - MEM_TO_SREG2=1, WB_TO_SREG2=1, MEM_RESULT=0xAA, WB_DATA=0xBB, SREG2_ADDR=7 -> OPERAND2=0xAA.
  - Same stimulus with SREG2_ADDR=0, REG_DATA2=0 -> OPERAND2=0.
- **Load-use:** MEM_IS_LOAD=1, MEM_TO_SREG1=1, SREG1_ADDR=3 -> STALL=1 for exactly one cycle. Next cycle, with WB_DATA=0xDEAD and hazard selects 0 -> OPERAND1=0xDEAD, STALL=0.
- **Shadow:** cycle 0 WB_WRITE_EN=1, WB_ADDR=9, WB_DATA=0x55. Cycle 1 no selects, SREG1_ADDR=9, REG_DATA1=0x11 -> OPERAND1=0x55.
- **Reset mid-stall:** enter LOAD_WAIT, assert RESET -> STALL=0, state RUN. Next cycle SREG1_ADDR=9 (prior shadow address) -> OPERAND1=REG_DATA1 (shadow cleared).
- **Counters (FWD_PERF_CNT_EN defined):** 3 MEM forwards + 1 load stall -> FWD_MEM_COUNT=3 (includes stall-detect cycle), LOAD_STALL_COUNT=1, FWD_WB_COUNT=1.
